// File: rtl/debug_pkg.sv
// Shared constants, FSM encodings and frame-size helper for the UART debug unit.
// DEBUG_CHECKSUM_EN adds the trailing XOR checksum state and byte.
package debug_pkg;

  localparam logic [7:0] CMD_CONT  = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_NEXT  = 8'h4E;
  localparam logic [7:0] CMD_DUMP  = 8'h44;
  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP_WAIT,
    ST_HDR,
    ST_FETCH,
    ST_SER,
    ST_WAIT_TX,
`ifdef DEBUG_CHECKSUM_EN
    ST_CKSUM,
`endif
    ST_DONE
  } state_t;

  // Which section of the frame the byte currently on the wire belongs to.
  typedef enum logic [2:0] {
    PH_HDR,
    PH_PC,
    PH_CYC,
    PH_REG,
    PH_MEM,
    PH_CK
  } phase_t;

  function automatic int frame_bytes(input int data_w, input int num_regs, input int mem_words);
    int n;
    n = 1 + (2 + num_regs + mem_words) * (data_w / 8);
`ifdef DEBUG_CHECKSUM_EN
    n = n + 1;
`endif
    return n;
  endfunction

endpackage

// File: rtl/debug_unit_if.sv
// Bundle of UART, CPU-control and state-read signals between debug_unit and its surroundings.
// master = debug_unit side, slave = UART/CPU side.
interface debug_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 5
);
  logic [7:0]        i_rx_data;
  logic              i_rx_done;
  logic              i_tx_done;
  logic              i_halt;
  logic [DATA_W-1:0] i_pc;
  logic [DATA_W-1:0] i_cycles;
  logic [REG_AW-1:0] o_reg_addr;
  logic [DATA_W-1:0] i_reg_data;
  logic [MEM_AW-1:0] o_mem_addr;
  logic [DATA_W-1:0] i_mem_data;
  logic              o_exec_mode;
  logic              o_step;
  logic              o_tx_start;
  logic [7:0]        o_tx_data;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_halt, i_pc, i_cycles, i_reg_data, i_mem_data,
    output o_reg_addr, o_mem_addr, o_exec_mode, o_step, o_tx_start, o_tx_data, o_busy, o_done
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_halt, i_pc, i_cycles, i_reg_data, i_mem_data,
    input  o_reg_addr, o_mem_addr, o_exec_mode, o_step, o_tx_start, o_tx_data, o_busy, o_done
  );
endinterface

// File: rtl/dbg_word_serializer.sv
// Holds one DATA_W word and presents it a byte at a time, MSB first; flags the
// acknowledge of the word's last byte.
module dbg_word_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_next,
  output logic [7:0]        o_byte,
  output logic              o_word_done
);
  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_W-1:0] shift_q;
  logic [CW-1:0]     cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (i_load) begin
      shift_q <= i_word;
      cnt_q   <= '0;
    end else if (i_next) begin
      shift_q <= shift_q << 8;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign o_byte      = shift_q[DATA_W-1 -: 8];
  assign o_word_done = i_next && (cnt_q == CW'(NB - 1));

endmodule

// File: rtl/debug_unit.sv
// UART debug controller: decodes run/step/dump commands and streams a state frame.
// Define DEBUG_CHECKSUM_EN to append an XOR checksum of all post-header bytes.
module debug_unit
  import debug_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 32,
  parameter int REG_AW    = (NUM_REGS  > 1) ? $clog2(NUM_REGS)  : 1,
  parameter int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  debug_unit_if.master  dbg
);

  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("debug_unit: DATA_W must be a multiple of 8");
  end

  state_t            state_q;
  phase_t            phase_q;
  logic              exec_mode_q, pending_q, halt_q, step_q;
  logic              tx_start_q, busy_q, done_q, fetch_hold_q;
  logic [7:0]        tx_data_q;
  logic [DATA_W-1:0] pc_q, cyc_q, ser_word;
  logic [REG_AW-1:0] reg_idx_q;
  logic [MEM_AW-1:0] mem_idx_q;
  logic              ser_load, ser_next, ser_word_done, byte_last;
  logic              reg_last, mem_last, words_end, halt_rise, single_byte;
  logic [7:0]        ser_byte;
`ifdef DEBUG_CHECKSUM_EN
  logic [7:0]        cksum_q;
`endif

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    ser_word = dbg.i_mem_data;
    case (phase_q)
      PH_PC:   ser_word = pc_q;
      PH_CYC:  ser_word = cyc_q;
      PH_REG:  ser_word = dbg.i_reg_data;
      default: ;
    endcase
  end

  assign single_byte = (phase_q == PH_HDR) || (phase_q == PH_CK);
  assign ser_load    = (state_q == ST_FETCH) && fetch_hold_q;
  assign ser_next    = (state_q == ST_WAIT_TX) && dbg.i_tx_done && !single_byte;
  assign byte_last   = single_byte || ser_word_done;
  assign reg_last    = (reg_idx_q == REG_AW'(NUM_REGS - 1));
  assign mem_last    = (mem_idx_q == MEM_AW'(MEM_WORDS - 1));
  assign words_end   = ((phase_q == PH_REG) && reg_last && (MEM_WORDS == 0)) ||
                       ((phase_q == PH_MEM) && mem_last);
  assign halt_rise   = dbg.i_halt && !halt_q;

  dbg_word_serializer #(.DATA_W(DATA_W)) u_ser (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (ser_load),
    .i_word      (ser_word),
    .i_next      (ser_next),
    .o_byte      (ser_byte),
    .o_word_done (ser_word_done)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_HDR;
      exec_mode_q  <= 1'b0;
      pending_q    <= 1'b0;
      halt_q       <= 1'b0;
      step_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fetch_hold_q <= 1'b0;
      tx_data_q    <= '0;
      pc_q         <= '0;
      cyc_q        <= '0;
      reg_idx_q    <= '0;
      mem_idx_q    <= '0;
`ifdef DEBUG_CHECKSUM_EN
      cksum_q      <= '0;
`endif
    end else begin
      halt_q     <= dbg.i_halt;
      step_q     <= 1'b0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (halt_rise) pending_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            pending_q <= halt_rise;
            busy_q    <= 1'b1;
            state_q   <= ST_HDR;
          end else if (dbg.i_rx_done) begin
            case (dbg.i_rx_data)
              CMD_CONT: exec_mode_q <= 1'b0;
              CMD_STEP: exec_mode_q <= 1'b1;
              CMD_DUMP: begin
                busy_q  <= 1'b1;
                state_q <= ST_HDR;
              end
              CMD_NEXT: begin
                if (exec_mode_q) begin
                  busy_q  <= 1'b1;
                  step_q  <= !dbg.i_halt;
                  state_q <= dbg.i_halt ? ST_HDR : ST_STEP_WAIT;
                end
              end
              default: ;
            endcase
          end
        end

        ST_STEP_WAIT: state_q <= ST_HDR;

        ST_HDR: begin
          pc_q       <= dbg.i_pc;
          cyc_q      <= dbg.i_cycles;
          tx_data_q  <= FRAME_HDR;
          tx_start_q <= 1'b1;
          phase_q    <= PH_HDR;
`ifdef DEBUG_CHECKSUM_EN
          cksum_q    <= '0;
`endif
          state_q    <= ST_WAIT_TX;
        end

        // First cycle presents the address, second captures the read data.
        ST_FETCH: begin
          fetch_hold_q <= !fetch_hold_q;
          if (fetch_hold_q) state_q <= ST_SER;
        end

        ST_SER: begin
          tx_data_q  <= ser_byte;
          tx_start_q <= 1'b1;
`ifdef DEBUG_CHECKSUM_EN
          cksum_q    <= cksum_q ^ ser_byte;
`endif
          state_q    <= ST_WAIT_TX;
        end

        ST_WAIT_TX: begin
          if (dbg.i_tx_done) begin
            if (!byte_last) begin
              state_q <= ST_SER;
            end else if (phase_q == PH_CK) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else if (words_end) begin
`ifdef DEBUG_CHECKSUM_EN
              state_q <= ST_CKSUM;
`else
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
`endif
            end else begin
              state_q <= ST_FETCH;
              case (phase_q)
                PH_HDR: phase_q <= PH_PC;
                PH_PC:  phase_q <= PH_CYC;
                PH_CYC: begin
                  phase_q   <= PH_REG;
                  reg_idx_q <= '0;
                end
                PH_REG: begin
                  if (!reg_last) begin
                    reg_idx_q <= reg_idx_q + 1'b1;
                  end else begin
                    phase_q   <= PH_MEM;
                    mem_idx_q <= '0;
                  end
                end
                default: mem_idx_q <= mem_idx_q + 1'b1;
              endcase
            end
          end
        end

`ifdef DEBUG_CHECKSUM_EN
        ST_CKSUM: begin
          tx_data_q  <= cksum_q;
          tx_start_q <= 1'b1;
          phase_q    <= PH_CK;
          state_q    <= ST_WAIT_TX;
        end
`endif

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dbg.o_reg_addr  = reg_idx_q;
  assign dbg.o_mem_addr  = mem_idx_q;
  assign dbg.o_exec_mode = exec_mode_q;
  assign dbg.o_step      = step_q;
  assign dbg.o_tx_start  = tx_start_q;
  assign dbg.o_tx_data   = tx_data_q;
  assign dbg.o_busy      = busy_q;
  assign dbg.o_done      = done_q;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit (DATA_W=32, NUM_REGS=4, MEM_WORDS=2) with a UART
// transmitter model and synchronous register/memory read models.
module tb_debug_unit;
  import debug_pkg::*;

`ifdef DEBUG_CHECKSUM_EN
  localparam int FLEN = 34;
`else
  localparam int FLEN = 33;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debug_unit_if #(.DATA_W(32), .REG_AW(2), .MEM_AW(1)) dbg ();

  debug_unit #(
    .DATA_W(32), .NUM_REGS(4), .MEM_WORDS(2), .REG_AW(2), .MEM_AW(1)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .dbg     (dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  int tx_delay = 2;
  int unstable = 0;
  int extra_start = 0;
  int done_cnt = 0;
  int step_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Register file R[i]=i, data memory M[i]=0x100+i, one-cycle read latency.
  always @(posedge clk) begin
    dbg.i_reg_data <= 32'(dbg.o_reg_addr);
    dbg.i_mem_data <= 32'h100 + 32'(dbg.o_mem_addr);
  end

  always @(negedge clk) begin
    if (dbg.o_done) done_cnt++;
    if (dbg.o_step) step_cnt++;
  end

  // Transmitter: accepts a byte on o_tx_start, acknowledges tx_delay cycles later.
  initial begin : tx_model
    logic [7:0] held;
    dbg.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (dbg.o_tx_start) begin
        held = dbg.o_tx_data;
        got_q.push_back(held);
        repeat (tx_delay - 1) begin
          @(negedge clk);
          if (dbg.o_tx_data !== held) unstable++;
          if (dbg.o_tx_start) extra_start++;
        end
        dbg.i_tx_done = 1'b1;
        @(negedge clk);
        dbg.i_tx_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    dbg.i_rx_data = b;
    dbg.i_rx_done = 1'b1;
    @(negedge clk);
    dbg.i_rx_done = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    check(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    for (int i = 0; i < budget && got_q.size() < target; i++) @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic build_exp(input logic [31:0] pc, input logic [31:0] cyc);
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    push_word(pc);
    push_word(cyc);
    for (int i = 0; i < 4; i++) push_word(32'(i));
    for (int i = 0; i < 2; i++) push_word(32'h100 + 32'(i));
`ifdef DEBUG_CHECKSUM_EN
    x = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) x = x ^ exp_q[i];
    exp_q.push_back(x);
`endif
  endtask

  task automatic compare_frame(input string tag, input int base);
    logic [7:0] v;
    for (int i = 0; i < exp_q.size(); i++) begin
      v = (base + i < got_q.size()) ? got_q[base + i] : 8'hxx;
      check($sformatf("%s_b%0d", tag, i), 32'(v), 32'(exp_q[i]));
    end
  endtask

  initial begin : main
    int base, dbase, sbase, sz;
    rst_n = 1'b0;
    dbg.i_rx_data = '0;
    dbg.i_rx_done = 1'b0;
    dbg.i_halt    = 1'b0;
    dbg.i_pc      = '0;
    dbg.i_cycles  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(dbg.o_tx_start), 0);
    check("rst_busy", 32'(dbg.o_busy), 0);
    check("rst_done", 32'(dbg.o_done), 0);
    check("rst_step", 32'(dbg.o_step), 0);
    check("rst_exec", 32'(dbg.o_exec_mode), 0);
    check("rst_tx_data", 32'(dbg.o_tx_data), 0);
    check("rst_reg_addr", 32'(dbg.o_reg_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain dump.
    dbg.i_pc = 32'h0000_0010;
    dbg.i_cycles = 32'd5;
    build_exp(32'h10, 32'd5);
    base = got_q.size(); dbase = done_cnt;
    send_byte(CMD_DUMP);
    wait_done("d_timeout", dbase + 1, 3000);
    repeat (20) @(negedge clk);
    check("d_len", 32'(got_q.size() - base), FLEN);
    check("d_pc_lsb", 32'(got_q[base + 4]), 32'h10);
    check("d_cyc_lsb", 32'(got_q[base + 8]), 32'h05);
    check("d_m1_lsb", 32'(got_q[base + 32]), 32'h01);
    compare_frame("d", base);
    check("d_done_once", 32'(done_cnt - dbase), 1);
    check("d_busy_low", 32'(dbg.o_busy), 0);

    // Step mode, single step with dump.
    send_byte(CMD_STEP);
    @(negedge clk);
    check("s_exec", 32'(dbg.o_exec_mode), 1);
    dbg.i_cycles = 32'h0000_0123;
    build_exp(32'h10, 32'h123);
    base = got_q.size(); dbase = done_cnt; sbase = step_cnt;
    send_byte(CMD_NEXT);
    wait_done("n_timeout", dbase + 1, 3000);
    repeat (20) @(negedge clk);
    check("n_step_once", 32'(step_cnt - sbase), 1);
    check("n_len", 32'(got_q.size() - base), FLEN);
    compare_frame("n", base);

    // 'N' in continuous mode is ignored.
    send_byte(CMD_CONT);
    @(negedge clk);
    check("c_exec", 32'(dbg.o_exec_mode), 0);
    base = got_q.size(); dbase = done_cnt; sbase = step_cnt;
    send_byte(CMD_NEXT);
    repeat (60) @(negedge clk);
    check("cn_no_bytes", 32'(got_q.size() - base), 0);
    check("cn_no_step", 32'(step_cnt - sbase), 0);
    check("cn_no_done", 32'(done_cnt - dbase), 0);

    // Halt rising mid-frame: frame completes, auto-dump follows.
    base = got_q.size(); dbase = done_cnt;
    send_byte(CMD_DUMP);
    wait_bytes(base + 5, 500);
    dbg.i_halt = 1'b1;
    wait_done("h_timeout", dbase + 2, 6000);
    repeat (20) @(negedge clk);
    check("h_two_frames", 32'(done_cnt - dbase), 2);
    check("h_len", 32'(got_q.size() - base), 2 * FLEN);
    check("h_hdr2", 32'(got_q[base + FLEN]), 32'hA5);
    compare_frame("h2", base + FLEN);
    dbg.i_halt = 1'b0;
    repeat (60) @(negedge clk);
    check("h_fall_no_dump", 32'(done_cnt - dbase), 2);

    // Command while busy is dropped.
    base = got_q.size(); dbase = done_cnt;
    send_byte(CMD_DUMP);
    repeat (10) @(negedge clk);
    check("b_busy", 32'(dbg.o_busy), 1);
    send_byte(CMD_DUMP);
    wait_done("b_timeout", dbase + 1, 3000);
    repeat (300) @(negedge clk);
    check("b_one_frame", 32'(done_cnt - dbase), 1);
    check("b_len", 32'(got_q.size() - base), FLEN);

    // Slow transmitter.
    tx_delay = 20;
    sbase = unstable; sz = extra_start;
    base = got_q.size(); dbase = done_cnt;
    send_byte(CMD_DUMP);
    wait_done("slow_timeout", dbase + 1, 6000);
    repeat (40) @(negedge clk);
    check("slow_stable", 32'(unstable - sbase), 0);
    check("slow_no_extra", 32'(extra_start - sz), 0);
    check("slow_len", 32'(got_q.size() - base), FLEN);
    compare_frame("slow", base);

    // Reset mid-frame abandons the frame.
    base = got_q.size();
    send_byte(CMD_DUMP);
    wait_bytes(base + 3, 2000);
    check("r_started", 32'(got_q.size() >= base + 3), 1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("r_tx_start", 32'(dbg.o_tx_start), 0);
    check("r_busy", 32'(dbg.o_busy), 0);
    check("r_done", 32'(dbg.o_done), 0);
    check("r_tx_data", 32'(dbg.o_tx_data), 0);
    rst_n = 1'b1;
    sz = got_q.size();
    repeat (200) @(negedge clk);
    check("r_no_more_bytes", 32'(got_q.size() - sz), 0);
    check("r_idle", 32'(dbg.o_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
